read_word: RTL and testbench

//  Reads one TGT_BITS word out of a DRAM-style row held in block RAM; read-side counterpart of the row-patch writer.

---
 rtl/read_word.sv | 158 +++++++++++++++
 tb/tb_read_word.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/read_word.sv
// read_word
//   Fetches one TGT_BITS word out of a DRAM-style row held in block RAM. This
//   is the read-side partner of the row-patch writer. A (row, word) request is
//   accepted in IDLE. The row is fetched over the BRAM read port, the word is
//   selected, and wordOut/wordValid are held until the consumer acks. The
//   block never writes the BRAM.
//
//   Optional feature: define READ_WORD_CACHE_EN to keep the last fetched row.
//   A request to that same row then skips the BRAM fetch and goes straight to
//   the word-select step. The cached row is invalidated only by reset.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   rdGo / rdRdy      request valid / ready (ready only in IDLE)
//   rowAdr, wdAdr     row address and word index, sampled on accept
//   bramAdr, bramRd   BRAM read address and one-cycle read strobe
//   bramRow           BRAM read data, BRAM_LATENCY cycles after bramRd
//   wordOut           selected word (0 on error)
//   wordValid         wordOut/rdErr valid, held until wordAck
//   wordAck           consumer accepts the word
//   rdErr             request had wdAdr >= WORDS_PER_ROW
module read_word #(
    parameter int ROW_BITS      = 1024,
    parameter int TGT_BITS      = 32,
    parameter int WORDS_PER_ROW = 32,
    parameter int BRAM_ADR_BITS = 5,
    parameter int ROW_ADR_BITS  = 10,
    parameter int BRAM_LATENCY  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdGo,
    output logic                     rdRdy,
    input  logic [ROW_ADR_BITS-1:0]  rowAdr,
    input  logic [BRAM_ADR_BITS-1:0] wdAdr,
    output logic [ROW_ADR_BITS-1:0]  bramAdr,
    output logic                     bramRd,
    input  logic [ROW_BITS-1:0]      bramRow,
    output logic [TGT_BITS-1:0]      wordOut,
    output logic                     wordValid,
    input  logic                     wordAck,
    output logic                     rdErr
);

    localparam int CNT_BITS = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;
    localparam logic [CNT_BITS-1:0] WAIT_LAST = CNT_BITS'(BRAM_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_EXTRACT, S_DONE
    } state_t;

    state_t                   state;
    logic [BRAM_ADR_BITS-1:0] wd_lat;
    logic [ROW_BITS-1:0]      row_reg;
    logic [CNT_BITS-1:0]      wait_cnt;

    logic accept;
    logic wd_bad;
    logic capture;
    logic cache_hit;

    // rdRdy is a registered copy of (state == IDLE), so accept is only
    // possible in IDLE and rdGo elsewhere is simply dropped.
    assign accept  = rdGo & rdRdy;
    // Widen before comparing so the check stays meaningful when
    // BRAM_ADR_BITS can address more words than a row holds.
    assign wd_bad  = 32'(wdAdr) >= 32'(WORDS_PER_ROW);
    // Last WAIT cycle: bramRow carries the requested row.
    assign capture = (state == S_WAIT) && (wait_cnt == WAIT_LAST);

`ifdef READ_WORD_CACHE_EN
    logic                    cache_vld;
    logic [ROW_ADR_BITS-1:0] cache_row;

    assign cache_hit = cache_vld && (rowAdr == cache_row);

    // bramAdr still holds the issued row while the fetch completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cache_vld <= 1'b0;
            cache_row <= '0;
        end else if (capture) begin
            cache_vld <= 1'b1;
            cache_row <= bramAdr;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rdRdy     <= 1'b1;
            bramRd    <= 1'b0;
            bramAdr   <= '0;
            wordOut   <= '0;
            wordValid <= 1'b0;
            rdErr     <= 1'b0;
            wd_lat    <= '0;
            wait_cnt  <= '0;
        end else begin
            // Strobe is a single-cycle pulse; only the accept path raises it.
            bramRd <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        wd_lat <= wdAdr;
                        rdRdy  <= 1'b0;
                        if (wd_bad) begin
                            state     <= S_DONE;
                            wordOut   <= '0;
                            rdErr     <= 1'b1;
                            wordValid <= 1'b1;
                        end else if (cache_hit) begin
                            state <= S_EXTRACT;
                        end else begin
                            state   <= S_ISSUE;
                            bramRd  <= 1'b1;
                            bramAdr <= rowAdr;
                        end
                    end
                end
                S_ISSUE: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (capture) begin
                        row_reg <= bramRow;
                        state   <= S_EXTRACT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_EXTRACT: begin
                    wordOut   <= row_reg[int'(wd_lat)*TGT_BITS +: TGT_BITS];
                    rdErr     <= 1'b0;
                    wordValid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (wordAck) begin
                        wordValid <= 1'b0;
                        rdErr     <= 1'b0;
                        rdRdy     <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    rdRdy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_word.sv
module tb_read_word;

    localparam int ROW_BITS     = 1024;
    localparam int TGT_BITS     = 32;
    localparam int WORDS        = 32;
    localparam int ADR_BITS     = 6;
    localparam int ROW_ADR_BITS = 10;
    localparam int LAT          = 1;
`ifdef READ_WORD_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdGo = 1'b0;
    logic wordAck = 1'b0;
    logic rdRdy, bramRd, wordValid, rdErr;
    logic [ROW_ADR_BITS-1:0] rowAdr = '0;
    logic [ROW_ADR_BITS-1:0] bramAdr;
    logic [ADR_BITS-1:0]     wdAdr = '0;
    logic [ROW_BITS-1:0]     bramRow = '0;
    logic [TGT_BITS-1:0]     wordOut;

    typedef struct {
        logic [31:0] word;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference state: cached row and last issued BRAM address
    bit       m_cache_vld = 1'b0;
    logic [9:0] m_cache_row = '0;
    logic [9:0] m_last_adr = '0;

    always #5 clk = ~clk;

    read_word #(
        .ROW_BITS(ROW_BITS), .TGT_BITS(TGT_BITS), .WORDS_PER_ROW(WORDS),
        .BRAM_ADR_BITS(ADR_BITS), .ROW_ADR_BITS(ROW_ADR_BITS), .BRAM_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdGo(rdGo), .rdRdy(rdRdy),
        .rowAdr(rowAdr), .wdAdr(wdAdr), .bramAdr(bramAdr), .bramRd(bramRd),
        .bramRow(bramRow), .wordOut(wordOut), .wordValid(wordValid),
        .wordAck(wordAck), .rdErr(rdErr)
    );

    // row 5 word i = A000_0000+i; other rows differ in bits [25:16]
    function automatic logic [31:0] word_val(input logic [9:0] r, input int i);
        logic [31:0] x;
        x = 32'(r ^ 10'd5);
        return (32'hA000_0000 + 32'(i)) ^ (x << 16);
    endfunction

    function automatic logic [ROW_BITS-1:0] row_data(input logic [9:0] r);
        logic [ROW_BITS-1:0] d;
        for (int i = 0; i < WORDS; i++) d[i*32 +: 32] = word_val(r, i);
        return d;
    endfunction

    function automatic logic [ROW_BITS-1:0] junk_row();
        logic [ROW_BITS-1:0] d;
        for (int i = 0; i < WORDS; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // one-cycle-latency BRAM; data is only valid for the one cycle after a read
    always @(posedge clk) begin
        if (bramRd) bramRow <= row_data(bramAdr);
        else        bramRow <= junk_row();
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // called at a negedge; holds reset for 'cycles' edges
    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        rdGo = 1'b0;
        wordAck = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
        m_cache_vld = 1'b0;
        m_last_adr = '0;
    endtask

    // called at a negedge with the DUT idle; returns at a negedge, DUT idle
    task automatic do_req(input int row, input int wd, input int hold);
        exp_t e;
        bit   err, hit, got;
        int   n, rd_cnt, exp_lat;
        err = (wd >= WORDS);
        hit = CACHE_EN && !err && m_cache_vld && (10'(row) == m_cache_row);
        exp_lat = err ? 1 : (hit ? 2 : 3 + LAT);
        e.err  = err;
        e.word = err ? 32'h0 : word_val(10'(row), wd);
        sb.push_back(e);

        chk("rdy_idle", rdRdy, 1);
        rdGo = 1'b1;
        rowAdr = 10'(row);
        wdAdr = 6'(wd);
        n = 0; got = 1'b0; rd_cnt = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                rdGo = 1'b0;
                chk("rdy_busy", rdRdy, 0);
            end
            if (bramRd) begin
                rd_cnt++;
                chk("bram_adr", bramAdr, 64'(row));
                chk("bram_rd_cycle", n, 1);
            end
            if (wordValid) got = 1'b1;
            else if (!err) wordAck = (n == 1);   // ack before DONE must be ignored
        end
        wordAck = 1'b0;
        chk("valid_seen", got, 1);
        e = sb.pop_front();
        if (!got) begin
            do_reset(2);
            return;
        end
        chk("latency", n, exp_lat);
        chk("bram_rd_cnt", rd_cnt, (hit || err) ? 0 : 1);
        chk("word", wordOut, e.word);
        chk("err", rdErr, e.err);
        if (!err && !hit) begin
            m_cache_vld = 1'b1;
            m_cache_row = 10'(row);
            m_last_adr  = 10'(row);
        end

        // hold phase: rdGo pulses must be dropped, output frozen
        for (int h = 0; h < hold; h++) begin
            rdGo = (h % 2 == 0);
            rowAdr = 10'($urandom_range(9, 0));
            @(negedge clk);
            chk("hold_valid", wordValid, 1);
            chk("hold_word", wordOut, e.word);
            chk("hold_err", rdErr, e.err);
            chk("hold_rdy", rdRdy, 0);
            chk("hold_bram_rd", bramRd, 0);
        end
        rdGo = 1'b0;
        wordAck = 1'b1;
        @(negedge clk);
        wordAck = 1'b0;
        chk("ack_valid", wordValid, 0);
        chk("ack_err", rdErr, 0);
        chk("ack_rdy", rdRdy, 1);
        chk("bram_adr_hold", bramAdr, m_last_adr);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rdy", rdRdy, 1);
        chk("rst_bram_rd", bramRd, 0);
        chk("rst_bram_adr", bramAdr, 0);
        chk("rst_word", wordOut, 0);
        chk("rst_valid", wordValid, 0);
        chk("rst_err", rdErr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(5, 7, 2);
        do_req(5, 7, 10);
        do_req(5, 31, 0);
        do_req(5, 0, 0);
        do_req(6, 3, 1);
        do_req(5, 32, 1);
        do_req(6, 63, 0);

        // reset while in WAIT abandons the request
        rdGo = 1'b1; rowAdr = 10'd7; wdAdr = 6'd2;
        @(negedge clk);
        rdGo = 1'b0;
        chk("abort_issue_rd", bramRd, 1);
        @(negedge clk);
        chk("abort_wait_rd", bramRd, 0);
        chk("abort_wait_valid", wordValid, 0);
        do_reset(1);
        chk("abort_rdy", rdRdy, 1);
        chk("abort_valid", wordValid, 0);
        chk("abort_bram_rd", bramRd, 0);
        chk("abort_err", rdErr, 0);

        do_req(5, 7, 0);
        do_req(5, 3, 0);
        do_req(6, 3, 0);
        for (int k = 0; k < 14; k++)
            do_req(int'($urandom_range(7, 4)), int'($urandom_range(33, 0)), int'($urandom_range(3, 0)));

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
